jpeg_rle_encoder: RTL and testbench

JPEG_RLE_ENCODER -- requirements
Module: jpeg_rle_encoder

---
 rtl/jpeg_rle_encoder.sv | 109 ++++++++++
 tb/tb_jpeg_rle_encoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_rle_encoder.sv
// jpeg_rle_encoder: turns 64-coefficient zigzag blocks into JPEG (run, size, amplitude) symbols.
// Handles DC prediction, ZRL expansion and EOB, with one registered output stage.
module jpeg_rle_encoder #(
  parameter int COEF_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_run,
  output logic [3:0]        out_size,
  output logic [COEF_W:0]   out_amp,
  output logic              out_is_dc,
  output logic              out_eob
);
  localparam int W1 = COEF_W + 1;
  localparam logic [1:0] ACCEPT = 2'd0, ZRL = 2'd1, SYM = 2'd2, EOB = 2'd3;
  logic [1:0]        r_state;
  logic [5:0]        r_idx, r_run;
  logic [1:0]        r_zrl;
  logic [COEF_W-1:0] r_pred;
  logic [3:0]        r_buf_run, r_buf_size, r_run_o, r_size_o;
  logic [W1-1:0]     r_buf_amp, r_amp_o;
  logic              r_valid, r_is_dc, r_eob;
  logic              w_take, w_fire, w_dc, w_nz, w_last, w_zrl_start, w_zrl_out, w_buf_out, w_eob_out, w_ld;
  logic [COEF_W-1:0] w_pred;
  logic [W1-1:0]     w_val, w_abs, w_mask, w_amp;
  logic [3:0]        w_size;

  function automatic logic [3:0] f_size(input logic [W1-1:0] a);
    f_size = 4'd0;
    for (int k = 0; k < W1; k++) if (a[k]) f_size = 4'(k + 1);
  endfunction

  always_comb begin
    w_take      = !r_valid || out_ready;
    in_ready    = (r_state == ACCEPT) && w_take;
    w_fire      = in_valid && in_ready;
    w_dc        = r_idx == 6'd0;
    w_nz        = in_coef != '0;
    w_last      = r_idx == 6'd63;
    w_pred      = blk_restart ? '0 : r_pred;
    w_val       = w_dc ? {in_coef[COEF_W-1], in_coef} - {w_pred[COEF_W-1], w_pred}
                       : {in_coef[COEF_W-1], in_coef};
    w_abs       = w_val[W1-1] ? -w_val : w_val;
    w_size      = f_size(w_abs);
    w_mask      = (W1'(1) << w_size) - W1'(1);
    w_amp       = w_val[W1-1] ? (w_val - W1'(1)) & w_mask : w_val;
    w_zrl_start = w_fire && !w_dc && w_nz && r_run[5:4] != 2'd0;
    w_zrl_out   = w_zrl_start || (r_state == ZRL && w_take);
    w_buf_out   = r_state == SYM && w_take;
    w_eob_out   = w_fire && !w_dc && !w_nz && w_last;
    w_ld        = (w_fire && (w_dc || w_nz || w_last)) || w_zrl_out || w_buf_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACCEPT;
      r_idx      <= '0;
      r_run      <= '0;
      r_zrl      <= '0;
      r_pred     <= '0;
      r_buf_run  <= '0;
      r_buf_size <= '0;
      r_buf_amp  <= '0;
      r_valid    <= 1'b0;
      r_run_o    <= '0;
      r_size_o   <= '0;
      r_amp_o    <= '0;
      r_is_dc    <= 1'b0;
      r_eob      <= 1'b0;
    end else begin
      if (w_take) r_valid <= w_ld;
      if (w_ld) begin
        r_run_o  <= w_zrl_out ? 4'd15 : w_buf_out ? r_buf_run : (w_dc || w_eob_out) ? 4'd0 : r_run[3:0];
        r_size_o <= w_buf_out ? r_buf_size : (w_zrl_out || w_eob_out) ? 4'd0 : w_size;
        r_amp_o  <= w_buf_out ? r_buf_amp : (w_zrl_out || w_eob_out) ? '0 : w_amp;
        r_is_dc  <= w_fire && w_dc;
        r_eob    <= w_eob_out;
      end
      if (w_fire && w_dc) r_pred <= in_coef;
      else if (blk_restart) r_pred <= '0;
      if (w_fire) begin
        r_idx <= r_idx + 6'd1;
        r_run <= (w_dc || w_nz || w_last) ? 6'd0 : r_run + 6'd1;
      end
      // the first ZRL goes out immediately; the real symbol waits in the buffer
      if (w_zrl_start) begin
        r_zrl                              <= r_run[5:4] - 2'd1;
        {r_buf_run, r_buf_size, r_buf_amp} <= {r_run[3:0], w_size, w_amp};
      end else if (r_state == ZRL && w_take) r_zrl <= r_zrl - 2'd1;
      if (w_zrl_start) r_state <= r_run[5:4] == 2'd1 ? SYM : ZRL;
      else if (w_eob_out) r_state <= EOB;
      else if (r_state == ZRL && w_take && r_zrl == 2'd1) r_state <= SYM;
      else if ((r_state == SYM || r_state == EOB) && w_take) r_state <= ACCEPT;
    end
  end

  assign out_valid = r_valid;
  assign out_run   = r_run_o;
  assign out_size  = r_size_o;
  assign out_amp   = r_amp_o;
  assign out_is_dc = r_is_dc;
  assign out_eob   = r_eob;
endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// tb_jpeg_rle_encoder: scoreboard bench for jpeg_rle_encoder with directed and random blocks.
module tb_jpeg_rle_encoder;
  localparam int CW = 11;
  localparam int W1 = CW + 1;
  typedef logic [2+8+W1-1:0] sym_t;

  logic          clk = 1'b0, rst = 1'b1, blk_restart = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, out_is_dc, out_eob;
  logic [CW-1:0] in_coef = '0;
  logic [3:0]    out_run, out_size;
  logic [W1-1:0] out_amp;
  logic [CW-1:0] blk[64];
  sym_t          exp_q[$], log_q[$], got, prev_sym, e;
  int            checks = 0, failures = 0, lowcnt = 0, stall_cnt = 0;
  int            m_idx = 0, m_run = 0, m_pred = 0;
  bit            rand_ready = 1'b0, prev_stall = 1'b0;

  jpeg_rle_encoder #(.COEF_W(CW)) dut (
    .clk(clk), .rst(rst), .blk_restart(blk_restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_coef(in_coef), .out_valid(out_valid), .out_ready(out_ready), .out_run(out_run),
    .out_size(out_size), .out_amp(out_amp), .out_is_dc(out_is_dc), .out_eob(out_eob)
  );

  always #5 clk = ~clk;
  assign got = {out_is_dc, out_eob, out_run, out_size, out_amp};

  function automatic sym_t mk(bit dc, bit eob, int run, int size, int amp);
    mk = {dc, eob, 4'(run), 4'(size), W1'(amp)};
  endfunction

  function automatic sym_t enc(bit dc, int run, int v);
    int a = v < 0 ? -v : v;
    int s = 0;
    while ((a >> s) != 0) s++;
    enc = mk(dc, 1'b0, run, s, v >= 0 ? v : v + (1 << s) - 1);
  endfunction

  task automatic model(input int c, input bit rs);
    if (m_idx == 0) begin
      exp_q.push_back(enc(1'b1, 0, c - (rs ? 0 : m_pred)));
      m_pred = c;
      m_run  = 0;
    end else if (c != 0) begin
      while (m_run >= 16) begin
        exp_q.push_back(mk(1'b0, 1'b0, 15, 0, 0));
        m_run -= 16;
      end
      exp_q.push_back(enc(1'b0, m_run, c));
      m_run = 0;
    end else begin
      m_run++;
      if (m_idx == 63) begin
        exp_q.push_back(mk(1'b0, 1'b1, 0, 0, 0));
        m_run = 0;
      end
    end
    m_idx = (m_idx + 1) % 64;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_idx = 0; m_run = 0; m_pred = 0;
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (got !== prev_sym) begin failures++; $display("FAIL stable got=%h required=%h", got, prev_sym); end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b required=0", in_ready); end
      end
      if (in_valid && in_ready) model(int'($signed(in_coef)), blk_restart);
      else if (blk_restart) m_pred = 0;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL unexpected_sym got=%h required=none", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin failures++; $display("FAIL sym got=%h required=%h", got, e); end
        end
        log_q.push_back(got);
      end
      prev_stall = out_valid && !out_ready;
      prev_sym   = got;
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin out_ready = 1'b0; stall_cnt--; end
    else out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic send(input int n, input bit rs);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      in_valid = 1'b1; in_coef = blk[i]; blk_restart = rs && i == 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin lowcnt++; t++; @(negedge clk); end
      if (t >= 200) begin checks++; failures++; $display("FAIL send_timeout idx=%0d in_ready=%b required=1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; blk_restart = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    checks++;
    if (t >= 500) begin failures++; $display("FAIL drain pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic fill_dense();
    for (int i = 0; i < 64; i++) begin
      int v = $urandom_range(1, 1023);
      blk[i] = CW'($urandom_range(0, 1) ? -v : v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_run, out_size, out_amp, out_is_dc, out_eob} !== '0) begin
      failures++; $display("FAIL reset_out got=%h required=0", {out_valid, got});
    end
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_dc_only();
    blk = '{default: '0}; blk[0] = CW'(5); log_q.delete();
    send(64, 1'b0); drain();
    checks++;
    if (log_q.size() != 2) begin failures++; $display("FAIL dc_only_count got=%0d required=2", log_q.size()); end
    checks++;
    if (log_q.size() < 1 || log_q[0] !== mk(1, 0, 0, 3, 5)) begin failures++; $display("FAIL dc_only_dc required=%h", mk(1, 0, 0, 3, 5)); end
    checks++;
    if (log_q.size() < 2 || log_q[1] !== mk(0, 1, 0, 0, 0)) begin failures++; $display("FAIL dc_only_eob required=%h", mk(0, 1, 0, 0, 0)); end
  endtask

  task automatic test_dc_diff();
    blk = '{default: '0}; blk[0] = CW'(3); log_q.delete();
    send(64, 1'b0); drain();
    checks++;
    if (log_q.size() < 1 || log_q[0] !== mk(1, 0, 0, 2, 1)) begin failures++; $display("FAIL dc_diff_neg required=%h", mk(1, 0, 0, 2, 1)); end
    blk_restart = 1'b1; @(posedge clk); #1; blk_restart = 1'b0;
    log_q.delete();
    send(64, 1'b0); drain();
    checks++;
    if (log_q.size() < 1 || log_q[0] !== mk(1, 0, 0, 2, 3)) begin failures++; $display("FAIL dc_restart_before required=%h", mk(1, 0, 0, 2, 3)); end
    blk[0] = CW'(-4); log_q.delete();
    send(64, 1'b1); drain();
    checks++;
    if (log_q.size() < 1 || log_q[0] !== mk(1, 0, 0, 3, 3)) begin failures++; $display("FAIL dc_restart_same required=%h", mk(1, 0, 0, 3, 3)); end
  endtask

  task automatic test_zrl();
    blk = '{default: '0}; blk[0] = CW'(5); blk[21] = CW'(-1); log_q.delete(); lowcnt = 0;
    send(64, 1'b0); drain();
    checks++;
    if (log_q.size() != 4) begin failures++; $display("FAIL zrl_count got=%0d required=4", log_q.size()); end
    checks++;
    if (log_q.size() < 2 || log_q[1] !== mk(0, 0, 15, 0, 0)) begin failures++; $display("FAIL zrl_sym required=%h", mk(0, 0, 15, 0, 0)); end
    checks++;
    if (log_q.size() < 3 || log_q[2] !== mk(0, 0, 4, 1, 0)) begin failures++; $display("FAIL zrl_ac required=%h", mk(0, 0, 4, 1, 0)); end
    checks++;
    if (lowcnt != 1) begin failures++; $display("FAIL zrl_in_ready_low got=%0d required=1", lowcnt); end
  endtask

  task automatic test_last_nonzero();
    blk = '{default: '0}; blk[0] = CW'(1); blk[63] = CW'(7); log_q.delete();
    send(64, 1'b0); drain();
    checks++;
    if (log_q.size() != 5) begin failures++; $display("FAIL last_count got=%0d required=5", log_q.size()); end
    checks++;
    if (log_q.size() < 4 || log_q[3] !== mk(0, 0, 15, 0, 0)) begin failures++; $display("FAIL last_zrl3 required=%h", mk(0, 0, 15, 0, 0)); end
    checks++;
    if (log_q.size() < 5 || log_q[4] !== mk(0, 0, 14, 3, 7)) begin failures++; $display("FAIL last_ac required=%h", mk(0, 0, 14, 3, 7)); end
  endtask

  task automatic test_back_to_back();
    lowcnt = 0;
    fill_dense(); send(64, 1'b0);
    fill_dense(); send(64, 1'b0);
    drain();
    checks++;
    if (lowcnt != 0) begin failures++; $display("FAIL b2b_in_ready_low got=%0d required=0", lowcnt); end
  endtask

  task automatic test_stall();
    lowcnt = 0;
    fill_dense();
    fork
      send(64, 1'b0);
      begin repeat (20) @(posedge clk); stall_cnt = 10; end
    join
    drain();
    checks++;
    if (lowcnt < 10) begin failures++; $display("FAIL stall_in_ready_low got=%0d required>=10", lowcnt); end
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    repeat (300) begin
      int d = $urandom_range(1, 10);
      for (int i = 0; i < 64; i++) blk[i] = ($urandom_range(0, d - 1) == 0) ? CW'($urandom_range(0, 2047)) : '0;
      send(64, $urandom_range(0, 19) == 0);
    end
    rand_ready = 1'b0;
    drain();
  endtask

  task automatic test_mid_reset();
    fill_dense();
    send(30, 1'b0);
    rst = 1'b1; @(posedge clk); #1;
    checks++;
    if ({out_valid, out_run, out_size, out_amp, out_is_dc, out_eob} !== '0) begin
      failures++; $display("FAIL mid_reset_out got=%h required=0", {out_valid, got});
    end
    rst = 1'b0;
    blk = '{default: '0}; blk[0] = CW'(9); log_q.delete();
    send(64, 1'b0); drain();
    checks++;
    if (log_q.size() < 1 || log_q[0] !== mk(1, 0, 0, 4, 9)) begin failures++; $display("FAIL mid_reset_dc required=%h", mk(1, 0, 0, 4, 9)); end
    checks++;
    if (log_q.size() != 2) begin failures++; $display("FAIL mid_reset_count got=%0d required=2", log_q.size()); end
  endtask

  initial begin
    test_reset();
    test_dc_only();
    test_dc_diff();
    test_zrl();
    test_last_nonzero();
    test_back_to_back();
    test_stall();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
